dispatch_ready_stage: RTL
=========================

# dispatch_ready_stage

Four-wide dispatch register stage that sits directly upstream of the issue window. It takes a renamed bundle of up to four instructions and holds it in an output register until the window accepts it. It keeps a physical-register ready table and computes each source's wake bit from three inputs: the table, same-cycle function-unit broadcasts, and dependencies on older instructions in the same bundle. While a bundle is stalled on a full window, its wake bits keep tracking broadcasts.

## Interface
- `PHY_REGS`, 64: physical register count; tag width is `$clog2(PHY_REGS)` = 6.
- `WIDTH`, 4: instructions per bundle. Fixed at 4 and not generalised.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: one clock; reset is synchronous and active-low.
- `flush` input 1: synchronous squash, same effect as reset except as noted below.
- `In_Valid` input 1: a renamed bundle is present.
- `In_Ready` output 1: the stage accepts the bundle this cycle.
- `InK_Valid`, `InK_Function[3:0]`, `InK_Operation[4:0]`, `InK_imm[31:0]`, `InK_PC[31:0]`, `InK_Phydst[5:0]`, `InK_Src1[5:0]`, `InK_Src2[5:0]`, `InK_Rdst[4:0]`, input, K=1..4: per-slot renamed fields. `Phydst`==0 means no destination.
- `ALU0_Commit`, `ALU1_Commit`, `BU_Commit`, `DU_Commit` input 1, each with `*_Phydst[5:0]` input: writeback wakeup broadcasts.
- `Issue_window_full` input 1: backpressure from the issue window.
- `InstK_Valid`, `InstK_Function`, `InstK_Operation`, `InstK_imm`, `InstK_PC`, `InstK_Phydst`, `InstK_Src1`, `InstK_Src2`, `InstK_Rdst` output, K=1..4: registered bundle to the issue window, same widths as the inputs.
- `InstK_Src1_Wake`, `InstK_Src2_Wake` output 1, K=1..4: source operand ready.

## Operation
- Output register holds `out_v` plus all bundle fields. `Inst1_Valid` = `out_v & In1_Valid_reg`. Slots 2–4 carry their own valid bits; the window keys on slot 1.
- Transfer: `xfer = out_v & !Issue_window_full`.
- `In_Ready = !out_v | !Issue_window_full`.
- Accept: `acc = In_Valid & In_Ready & In1_Valid`. On accept the output register loads the bundle and `out_v` is set to 1. Otherwise, if `xfer`, `out_v` is cleared to 0.
- Ready table `rdy[0:63]`:
  - Reset and flush set every entry to 1.
  - `rdy[0]` is hard-wired to 1.
  - Each broadcast with `*_Commit`=1 sets `rdy[tag]`.
  - Each accepted slot K with `InK_Valid` and `InK_Phydst`≠0 clears `rdy[InK_Phydst]`.
  - If a set and a clear hit the same tag in the same cycle, the clear wins.
- Wake bit at accept, for slot K source S, stored in `wreg`:
  - (`rdy[S]` OR a broadcast this cycle matching S),
  - AND NOT (some older slot J<K in the bundle is valid, has `Phydst`≠0, and `Phydst`==S).
  - S==0 is always woken.
- Held update: while `out_v` and no accept, each stored wake bit ORs in this cycle's broadcast matches against its registered source tag.
- Output wake: `InstK_SrcN_Wake = wreg | (broadcast match on registered tag this cycle)`. This combinational OR is required because the window overwrites its wake bits on its write cycle and would otherwise lose same-cycle broadcasts.
- Flush also clears `out_v` and all stored wake bits. Any incoming bundle in the same cycle is dropped.

## Timing
- Latency: bundle accepted at edge N appears at the outputs after edge N; it can transfer in cycle N+1 at the earliest.
- Throughput: one bundle per cycle when `Issue_window_full`=0.
- Reset values: `In_Ready`=1. All `Inst*` outputs are 0, including valid and wake. `rdy` is all ones.
- Reset or flush mid-stall discards the held bundle. Wake ORs from broadcasts in that cycle are ignored.
- A new `In_Valid` bundle is accepted in the same cycle the held bundle transfers (pass-through, no bubble).

## Structure
- Shared package (`define.v`): tag width, `PHY_REGS`, the `Function` one-hot bit positions (ALU=0, BU=1, LOAD=2, STORE=3), and `NO_DST`=0.
- One sub-module `wake_match`: one 6-bit tag against 4 broadcast (valid, tag) pairs, producing a 1-bit hit. It is instanced for the table bypass, the held update, and the output OR.

## Test plan
- Reset, then a bundle with `In1..4_Phydst`=33,34,35,36 and all sources 1..8: outputs appear one cycle later with all wake bits =1. Then `rdy[33..36]`=0.
- Next bundle: `In2_Src1`=33, `In3_Src2`=In1_Phydst=40. Required: `Inst2_Src1_Wake`=0 (table) and `Inst3_Src2_Wake`=0 (intra-bundle dependency).
- `Issue_window_full`=1 for 3 cycles with `Inst2_Src1`=33 held; `ALU1_Commit` with tag 33 in cycle 2. Required: wake becomes 1 combinationally in cycle 2 and stays 1. `In_Ready`=0 throughout.
- `DU_Commit` with tag 34 in the same cycle a slot with `Src1`=34 is accepted: stored wake =1. The same tag also allocated as `Phydst` in that cycle: `rdy[34]`=0 (clear wins).
- Stall with `out_v`=1, then assert `flush`: the next cycle has `Inst1_Valid`=0, `In_Ready`=1, and `rdy[33..40]`=1.
- Full window released while `In_Valid`=1: the new bundle is loaded at the same edge as the transfer, and `out_v` stays 1 with no bubble.

Source files
------------

// File: rtl/dispatch_ready_stage_pkg.sv
// Shared widths, function-unit bit positions and the dispatch slot record
// for the dispatch ready stage.
package dispatch_ready_stage_pkg;
    localparam int PHY_REGS = 64;
    localparam int TAG_W    = $clog2(PHY_REGS);
    localparam int WIDTH    = 4;
    localparam int N_BC     = 4;

    localparam logic [TAG_W-1:0] NO_DST = '0;

    localparam int FN_ALU   = 0;
    localparam int FN_BU    = 1;
    localparam int FN_LOAD  = 2;
    localparam int FN_STORE = 3;

    typedef struct packed {
        logic             valid;
        logic [3:0]       func;
        logic [4:0]       op;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] phydst;
        logic [TAG_W-1:0] src1;
        logic [TAG_W-1:0] src2;
        logic [4:0]       rdst;
    } slot_t;
endpackage

// File: rtl/dispatch_ready_stage_wake_match.sv
// Compares one physical tag against the four writeback broadcasts.
module wake_match
    import dispatch_ready_stage_pkg::*;
(
    input  logic [TAG_W-1:0]      tag,
    input  logic [N_BC-1:0]       bc_valid,
    input  logic [N_BC*TAG_W-1:0] bc_tags,
    output logic                  hit
);
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_BC; i++) begin
            if (bc_valid[i] && (bc_tags[i*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
    end
endmodule

// File: rtl/dispatch_ready_stage.sv
// Four-wide dispatch register stage: holds a renamed bundle for the issue window
// and keeps per-source wake bits current against the ready table and broadcasts.
module dispatch_ready_stage
    import dispatch_ready_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic        In1_Valid, In2_Valid, In3_Valid, In4_Valid,
    input  logic [3:0]  In1_Function, In2_Function, In3_Function, In4_Function,
    input  logic [4:0]  In1_Operation, In2_Operation, In3_Operation, In4_Operation,
    input  logic [31:0] In1_imm, In2_imm, In3_imm, In4_imm,
    input  logic [31:0] In1_PC, In2_PC, In3_PC, In4_PC,
    input  logic [5:0]  In1_Phydst, In2_Phydst, In3_Phydst, In4_Phydst,
    input  logic [5:0]  In1_Src1, In2_Src1, In3_Src1, In4_Src1,
    input  logic [5:0]  In1_Src2, In2_Src2, In3_Src2, In4_Src2,
    input  logic [4:0]  In1_Rdst, In2_Rdst, In3_Rdst, In4_Rdst,
    input  logic        ALU0_Commit, ALU1_Commit, BU_Commit, DU_Commit,
    input  logic [5:0]  ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst,
    input  logic        Issue_window_full,
    output logic        Inst1_Valid, Inst2_Valid, Inst3_Valid, Inst4_Valid,
    output logic [3:0]  Inst1_Function, Inst2_Function, Inst3_Function, Inst4_Function,
    output logic [4:0]  Inst1_Operation, Inst2_Operation, Inst3_Operation, Inst4_Operation,
    output logic [31:0] Inst1_imm, Inst2_imm, Inst3_imm, Inst4_imm,
    output logic [31:0] Inst1_PC, Inst2_PC, Inst3_PC, Inst4_PC,
    output logic [5:0]  Inst1_Phydst, Inst2_Phydst, Inst3_Phydst, Inst4_Phydst,
    output logic [5:0]  Inst1_Src1, Inst2_Src1, Inst3_Src1, Inst4_Src1,
    output logic [5:0]  Inst1_Src2, Inst2_Src2, Inst3_Src2, Inst4_Src2,
    output logic [4:0]  Inst1_Rdst, Inst2_Rdst, Inst3_Rdst, Inst4_Rdst,
    output logic        Inst1_Src1_Wake, Inst2_Src1_Wake, Inst3_Src1_Wake, Inst4_Src1_Wake,
    output logic        Inst1_Src2_Wake, Inst2_Src2_Wake, Inst3_Src2_Wake, Inst4_Src2_Wake
);
    slot_t in_slot  [WIDTH];
    slot_t out_slot [WIDTH];

    logic                  out_v, acc, xfer, slot1_valid;
    logic [WIDTH-1:0]      wreg1, wreg2;
    logic [WIDTH-1:0]      byp1, byp2, held1, held2, dep1, dep2, new1, new2;
    logic [PHY_REGS-1:0]   rdy, rdy_nxt, set_mask, clr_mask;
    logic [N_BC-1:0]       bc_valid;
    logic [N_BC*TAG_W-1:0] bc_tags;

    assign bc_valid = {DU_Commit, BU_Commit, ALU1_Commit, ALU0_Commit};
    assign bc_tags  = {DU_Phydst, BU_Phydst, ALU1_Phydst, ALU0_Phydst};

    assign in_slot[0] = {In1_Valid, In1_Function, In1_Operation, In1_imm, In1_PC,
                         In1_Phydst, In1_Src1, In1_Src2, In1_Rdst};
    assign in_slot[1] = {In2_Valid, In2_Function, In2_Operation, In2_imm, In2_PC,
                         In2_Phydst, In2_Src1, In2_Src2, In2_Rdst};
    assign in_slot[2] = {In3_Valid, In3_Function, In3_Operation, In3_imm, In3_PC,
                         In3_Phydst, In3_Src1, In3_Src2, In3_Rdst};
    assign in_slot[3] = {In4_Valid, In4_Function, In4_Operation, In4_imm, In4_PC,
                         In4_Phydst, In4_Src1, In4_Src2, In4_Rdst};

    assign {slot1_valid, Inst1_Function, Inst1_Operation, Inst1_imm, Inst1_PC,
            Inst1_Phydst, Inst1_Src1, Inst1_Src2, Inst1_Rdst} = out_slot[0];
    assign {Inst2_Valid, Inst2_Function, Inst2_Operation, Inst2_imm, Inst2_PC,
            Inst2_Phydst, Inst2_Src1, Inst2_Src2, Inst2_Rdst} = out_slot[1];
    assign {Inst3_Valid, Inst3_Function, Inst3_Operation, Inst3_imm, Inst3_PC,
            Inst3_Phydst, Inst3_Src1, Inst3_Src2, Inst3_Rdst} = out_slot[2];
    assign {Inst4_Valid, Inst4_Function, Inst4_Operation, Inst4_imm, Inst4_PC,
            Inst4_Phydst, Inst4_Src1, Inst4_Src2, Inst4_Rdst} = out_slot[3];

    assign Inst1_Valid = out_v & slot1_valid;
    assign In_Ready    = ~out_v | ~Issue_window_full;
    assign xfer        = out_v & ~Issue_window_full;
    assign acc         = In_Valid & In_Ready & In1_Valid & ~flush;

    // The window overwrites its wake bits on write, so same-cycle broadcasts ride along here.
    assign {Inst4_Src1_Wake, Inst3_Src1_Wake, Inst2_Src1_Wake, Inst1_Src1_Wake} = wreg1 | held1;
    assign {Inst4_Src2_Wake, Inst3_Src2_Wake, Inst2_Src2_Wake, Inst1_Src2_Wake} = wreg2 | held2;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        wake_match u_byp1  (.tag(in_slot[k].src1),  .bc_valid(bc_valid), .bc_tags(bc_tags), .hit(byp1[k]));
        wake_match u_byp2  (.tag(in_slot[k].src2),  .bc_valid(bc_valid), .bc_tags(bc_tags), .hit(byp2[k]));
        wake_match u_held1 (.tag(out_slot[k].src1), .bc_valid(bc_valid), .bc_tags(bc_tags), .hit(held1[k]));
        wake_match u_held2 (.tag(out_slot[k].src2), .bc_valid(bc_valid), .bc_tags(bc_tags), .hit(held2[k]));
    end

    always_comb begin
        dep1 = '0;
        dep2 = '0;
        new1 = '0;
        new2 = '0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (in_slot[j].valid && (in_slot[j].phydst != NO_DST)) begin
                    if (in_slot[j].phydst == in_slot[k].src1) dep1[k] = 1'b1;
                    if (in_slot[j].phydst == in_slot[k].src2) dep2[k] = 1'b1;
                end
            end
            new1[k] = (in_slot[k].src1 == NO_DST) | ((rdy[in_slot[k].src1] | byp1[k]) & ~dep1[k]);
            new2[k] = (in_slot[k].src2 == NO_DST) | ((rdy[in_slot[k].src2] | byp2[k]) & ~dep2[k]);
        end
    end

    // Allocation clears are applied after broadcast sets so a same-tag clear wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < N_BC; i++) begin
            if (bc_valid[i]) set_mask[bc_tags[i*TAG_W +: TAG_W]] = 1'b1;
        end
        if (acc) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (in_slot[k].valid && (in_slot[k].phydst != NO_DST)) clr_mask[in_slot[k].phydst] = 1'b1;
            end
        end
        rdy_nxt    = (rdy | set_mask) & ~clr_mask;
        rdy_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            out_v <= 1'b0;
            wreg1 <= '0;
            wreg2 <= '0;
            rdy   <= '1;
            for (int k = 0; k < WIDTH; k++) out_slot[k] <= '0;
        end else begin
            rdy <= rdy_nxt;
            if (acc) begin
                out_v <= 1'b1;
                wreg1 <= new1;
                wreg2 <= new2;
                for (int k = 0; k < WIDTH; k++) out_slot[k] <= in_slot[k];
            end else begin
                if (out_v) begin
                    wreg1 <= wreg1 | held1;
                    wreg2 <= wreg2 | held2;
                end
                if (xfer) out_v <= 1'b0;
            end
        end
    end
endmodule
